// File: rtl/display_scan_scheduler.sv
// Four-digit seven-segment scan scheduler: blanked digit slots and a
// frame-synchronous scrolling 4-character window over a 16-entry buffer.
module display_scan_scheduler #(
   parameter int DIGIT_TICKS   = 4096,
   parameter int BLANK_TICKS   = 256,
   parameter int SCROLL_FRAMES = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       step,
   input  logic       auto_en,
   input  logic       wr_en,
   input  logic [3:0] wr_addr,
   input  logic [3:0] wr_data,
   output logic [3:0] char,
   output logic       an3,
   output logic       an2,
   output logic       an1,
   output logic       an0,
   output logic [3:0] offset,
   output logic       frame_start
);

   localparam int CW = $clog2(DIGIT_TICKS);
   localparam int FW = (SCROLL_FRAMES > 1) ?
                       $clog2(SCROLL_FRAMES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_TICKS - 1);
   localparam logic [FW-1:0] AFC_LAST = FW'(SCROLL_FRAMES - 1);

   typedef enum logic [1:0] {
      D0 = 2'd0,
      D1 = 2'd1,
      D2 = 2'd2,
      D3 = 2'd3
   } dig_e;

   dig_e          dig, dig_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [3:0]    off_q, off_nx;
   logic          pend, pend_nx;
   logic [FW-1:0] afc, afc_nx;
   logic [3:0]    msg [16];
   logic [3:0]    char_q;
   logic [3:0]    an_q, an_nx;
   logic          fs_q, fs_nx;
   logic          slot_end;
   logic          boundary;
   logic          auto_tick;
   logic          req;
   logic [3:0]    sel_nx;

   always_comb begin
      slot_end  = (cnt == CNT_LAST);
      boundary  = slot_end && (dig == D0);
      auto_tick = auto_en && boundary && (afc == AFC_LAST);
      req       = pend || step || auto_tick;

      cnt_nx = slot_end ? '0 : cnt + 1'b1;

      dig_nx = dig;
      if (slot_end) begin
         unique case (dig)
            D3: dig_nx = D2;
            D2: dig_nx = D1;
            D1: dig_nx = D0;
            D0: dig_nx = D3;
         endcase
      end

      off_nx  = (boundary && req) ? off_q + 4'd1 : off_q;
      pend_nx = boundary ? 1'b0 : (pend || step);

      // counter is parked at zero whenever auto-scroll is off
      if (!auto_en)
         afc_nx = '0;
      else if (boundary)
         afc_nx = auto_tick ? '0 : afc + 1'b1;
      else
         afc_nx = afc;

      // digit d shows msg[offset + 3 - d]; 3 - d == ~d in 2 bits
      sel_nx = off_nx + {2'b00, ~dig_nx};

      an_nx = 4'b1111;
      if (int'(cnt_nx) >= BLANK_TICKS) begin
         unique case (dig_nx)
            D3: an_nx = 4'b0111;
            D2: an_nx = 4'b1011;
            D1: an_nx = 4'b1101;
            D0: an_nx = 4'b1110;
         endcase
      end

      fs_nx = (cnt_nx == '0) && (dig_nx == D3);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         dig    <= D3;
         off_q  <= '0;
         pend   <= 1'b0;
         afc    <= '0;
         char_q <= '0;
         an_q   <= 4'b1111;
         fs_q   <= 1'b1;
      end else begin
         cnt   <= cnt_nx;
         dig   <= dig_nx;
         off_q <= off_nx;
         pend  <= pend_nx;
         afc   <= afc_nx;
         an_q  <= an_nx;
         fs_q  <= fs_nx;
         if (slot_end)
            char_q <= msg[sel_nx];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++)
            msg[i] <= 4'(i);
      end else if (wr_en) begin
         msg[wr_addr] <= wr_data;
      end
   end

   assign char                 = char_q;
   assign {an3, an2, an1, an0} = an_q;
   assign offset               = off_q;
   assign frame_start          = fs_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Bench for display_scan_scheduler: timeline model checked every
// cycle, plus literal pins at hand-picked cycles.
module tb_display_scan_scheduler;

   localparam int DT    = 8;
   localparam int BL    = 2;
   localparam int SF    = 2;
   localparam int FRAME = 4 * DT;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       step = 1'b0;
   logic       auto_en = 1'b0;
   logic       wr_en = 1'b0;
   logic [3:0] wr_addr = '0;
   logic [3:0] wr_data = '0;
   logic [3:0] char;
   logic [3:0] offset;
   logic       an3, an2, an1, an0;
   logic       frame_start;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   display_scan_scheduler #(
      .DIGIT_TICKS  (DT),
      .BLANK_TICKS  (BL),
      .SCROLL_FRAMES(SF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .step       (step),
      .auto_en    (auto_en),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .char       (char),
      .an3        (an3),
      .an2        (an2),
      .an1        (an1),
      .an0        (an0),
      .offset     (offset),
      .frame_start(frame_start)
   );

   // timeline model: t = cycles since reset release
   int         t;
   int         moff;
   int         mafc;
   bit         mreq;
   bit         mvalid = 1'b0;
   logic [3:0] mmsg [16];
   logic [3:0] mchar;

   always @(posedge clk) begin
      if (reset) begin
         t = 0; moff = 0; mafc = 0;
         mreq = 1'b0; mchar = 4'h0; mvalid = 1'b1;
         for (int i = 0; i < 16; i++) mmsg[i] = 4'(i);
      end else if (mvalid) begin
         if (step) mreq = 1'b1;
         if (t % FRAME == FRAME - 1) begin
            if (!auto_en) mafc = 0;
            else if (mafc == SF - 1) begin
               mreq = 1'b1;
               mafc = 0;
            end else mafc++;
            if (mreq) moff = (moff + 1) % 16;
            mreq = 1'b0;
         end
         t++;
         if (t % DT == 0)
            mchar = mmsg[(moff + (t / DT) % 4) % 16];
         if (wr_en) mmsg[wr_addr] = wr_data;
      end
   end

   function automatic logic [3:0] exp_an();
      int ph, sl;
      logic [3:0] one;
      ph = t % DT;
      sl = (t / DT) % 4;
      one = 4'b1000;
      if (ph < BL) return 4'b1111;
      return ~(one >> sl);
   endfunction

   task automatic check(input string name,
                        input logic [7:0] got,
                        input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d, %0t)",
                  name, got, exp, cyc, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mvalid) begin
         check("m_an", {4'h0, an3, an2, an1, an0}, {4'h0, exp_an()});
         check("m_char", {4'h0, char}, {4'h0, mchar});
         check("m_offset", {4'h0, offset}, 8'(moff));
         check("m_fs", {7'h0, frame_start},
               {7'h0, (t % FRAME == 0)});
      end
   end

   task automatic go_to(input int c);
      while (cyc < c) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      cyc = 0;
   endtask

   task automatic pulse(input int c);
      go_to(c);
      step = 1'b1;
      go_to(c + 1);
      step = 1'b0;
   endtask

   task automatic wr(input int c, input logic [3:0] a,
                     input logic [3:0] d);
      go_to(c);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      go_to(c + 1);
      wr_en = 1'b0;
   endtask

   function automatic logic [7:0] an4();
      return {4'h0, an3, an2, an1, an0};
   endfunction

   initial begin
      do_reset();
      // scan order and blanking
      check("p0_an", an4(), 8'hF);
      check("p0_char", {4'h0, char}, 8'h0);
      check("p0_fs", {7'h0, frame_start}, 8'h1);
      check("p0_off", {4'h0, offset}, 8'h0);
      go_to(1);  check("p1_an", an4(), 8'hF);
      check("p1_fs", {7'h0, frame_start}, 8'h0);
      go_to(2);  check("p2_an", an4(), 8'h7);
      check("p2_char", {4'h0, char}, 8'h0);
      go_to(8);  check("p8_an", an4(), 8'hF);
      check("p8_char", {4'h0, char}, 8'h1);
      go_to(10); check("p10_an", an4(), 8'hB);
      pulse(10);
      go_to(18); check("p18_an", an4(), 8'hD);
      check("p18_char", {4'h0, char}, 8'h2);
      go_to(26); check("p26_an", an4(), 8'hE);
      check("p26_char", {4'h0, char}, 8'h3);
      check("p26_off", {4'h0, offset}, 8'h0);
      go_to(32); check("p32_fs", {7'h0, frame_start}, 8'h1);
      check("p32_off", {4'h0, offset}, 8'h1);
      go_to(34); check("p34_char", {4'h0, char}, 8'h1);
      go_to(58); check("p58_char", {4'h0, char}, 8'h4);
      // steps plus coinciding auto tick collapse to one
      go_to(64); auto_en = 1'b1;
      pulse(101);
      pulse(116);
      go_to(127); check("p127_off", {4'h0, offset}, 8'h1);
      go_to(128); auto_en = 1'b0;
      check("p128_off", {4'h0, offset}, 8'h2);
      go_to(130); check("p130_char", {4'h0, char}, 8'h2);
      // auto scroll every two frames, then freeze and clear
      go_to(160); auto_en = 1'b1;
      go_to(200); check("p200_off", {4'h0, offset}, 8'h2);
      go_to(230); check("p230_off", {4'h0, offset}, 8'h3);
      go_to(260); check("p260_off", {4'h0, offset}, 8'h3);
      go_to(290); check("p290_off", {4'h0, offset}, 8'h4);
      go_to(330); auto_en = 1'b0;
      go_to(420); check("p420_off", {4'h0, offset}, 8'h4);
      auto_en = 1'b1;
      go_to(450); check("p450_off", {4'h0, offset}, 8'h4);
      go_to(482); check("p482_off", {4'h0, offset}, 8'h5);
      check("p482_char", {4'h0, char}, 8'h5);
      auto_en = 1'b0;

      // buffer write during a displayed slot, then mid-slot reset
      do_reset();
      check("r2_an", an4(), 8'hF);
      wr(10, 4'd1, 4'd9);
      go_to(12); check("w12_char", {4'h0, char}, 8'h1);
      go_to(15); check("w15_char", {4'h0, char}, 8'h1);
      go_to(40); check("w40_char", {4'h0, char}, 8'h9);
      go_to(43);
      do_reset();
      check("r3_an", an4(), 8'hF);
      check("r3_char", {4'h0, char}, 8'h0);
      check("r3_off", {4'h0, offset}, 8'h0);
      go_to(10); check("r3_msg1", {4'h0, char}, 8'h1);
      wr(39, 4'd1, 4'd5);
      check("w40b_char", {4'h0, char}, 8'h1);
      pulse(63);
      check("s64_off", {4'h0, offset}, 8'h1);
      check("s64_char", {4'h0, char}, 8'h5);
      go_to(72); check("w72_char", {4'h0, char}, 8'h2);

      // wrap of the window offset
      do_reset();
      for (int f = 0; f < 14; f++) pulse(f * FRAME + 15);
      go_to(450); check("x450_off", {4'h0, offset}, 8'hE);
      check("x450_char", {4'h0, char}, 8'hE);
      go_to(458); check("x458_char", {4'h0, char}, 8'hF);
      pulse(463);
      go_to(466); check("x466_char", {4'h0, char}, 8'h0);
      go_to(474); check("x474_char", {4'h0, char}, 8'h1);
      go_to(482); check("x482_off", {4'h0, offset}, 8'hF);
      pulse(511);
      go_to(514); check("x514_off", {4'h0, offset}, 8'h0);
      check("x514_char", {4'h0, char}, 8'h0);
      check("x514_an", an4(), 8'h7);
      go_to(522); check("x522_char", {4'h0, char}, 8'h1);
      go_to(530); check("x530_char", {4'h0, char}, 8'h2);
      go_to(538); check("x538_char", {4'h0, char}, 8'h3);
      check("x538_an", an4(), 8'hE);
      go_to(545);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
